debug_panel: RTL and testbench

Two-button board debug panel: debounces both push-buttons, classifies presses as short, long, or two-button chord, and uses them to step a selector through `N_STATES` probe words. The selected word is driven to the LED bank through a stability filter, with an optional freeze. It sits at the top level between the raw button/LED pins and the internal probe buses, and drives the design-wide debug reset. This block is the successor to the fixed two-button click-mux debug wrapper: it adds bidirectional stepping, long-press actions, freeze, and a selection-aware display filter.

---
 rtl/debug_panel.sv | 185 ++++++++++++++++++
 tb/tb_debug_panel.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/debug_panel.sv
// Two-button debug panel: debounce, short/long/chord press decode, probe
// selector with wrap-around stepping, freeze, and a stability-filtered LED
// display of the selected probe word.

// One button: synchroniser, debouncer and press-duration classifier.
module debug_btn #(
  parameter int DEADZONE_WIDTH    = 1024,
  parameter int LONG_PRESS_CYCLES = 1024*1024*25
) (
  input  logic clk,
  input  logic i_reset,
  input  logic raw,
  input  logic chord_any,
  output logic level,
  output logic short_p,
  output logic long_p
);
  localparam int DZW = (DEADZONE_WIDTH > 1) ? $clog2(DEADZONE_WIDTH) : 1;
  localparam int LPW = $clog2(LONG_PRESS_CYCLES + 1);

  logic           sync1, sync2;
  logic [DZW-1:0] db_cnt;
  logic [LPW-1:0] dur;
  logic           spoiled;
  logic           quiet;

  // Pulses are withheld while a chord is live or the current press was
  // tainted by a chord or by a reset that landed mid-press.
  assign quiet = spoiled | chord_any;

  // Synchroniser is left unreset so a button held through reset still reads
  // as held, which is what keeps that press from acting afterwards.
  always_ff @(posedge clk) begin
    sync1 <= raw;
    sync2 <= sync1;
  end

  // Debounce: level flips only after the synchronised input disagrees for
  // DEADZONE_WIDTH consecutive cycles.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (sync2 == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DZW'(DEADZONE_WIDTH - 1)) begin
      level  <= ~level;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Press classifier: saturating duration count, LONG at threshold, SHORT on
  // release of a press that never reached it. Spoiled is set by reset and
  // chords and clears once the button is genuinely released.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      dur     <= '0;
      short_p <= 1'b0;
      long_p  <= 1'b0;
      spoiled <= 1'b1;
    end else begin
      short_p <= 1'b0;
      long_p  <= 1'b0;
      if (level) begin
        if (dur != LPW'(LONG_PRESS_CYCLES)) dur <= dur + 1'b1;
        if (dur == LPW'(LONG_PRESS_CYCLES - 1) && !quiet) long_p <= 1'b1;
      end else begin
        if (dur != '0 && dur != LPW'(LONG_PRESS_CYCLES) && !quiet) short_p <= 1'b1;
        dur <= '0;
      end
      if (level && chord_any)   spoiled <= 1'b1;
      else if (!level && !sync2) spoiled <= 1'b0;
    end
  end
endmodule

module debug_panel #(
  parameter int WIDTH             = 8,
  parameter int N_STATES          = 4,
  parameter int DEADZONE_WIDTH    = 1024,
  parameter int LONG_PRESS_CYCLES = 1024*1024*25,
  parameter int DISPLAY_STABLE    = 1024*1024*50
) (
  input  logic                               clk,
  input  logic                               i_reset,
  input  logic [1:0]                         i_buttons,
  input  logic [N_STATES-1:0][WIDTH-1:0]     i_x,
  output logic [1:0]                         o_buttons,
  output logic [$clog2(N_STATES)-1:0]        o_sel,
  output logic                               o_frozen,
  output logic [WIDTH-1:0]                   o_display,
  output logic                               o_reset
);
  localparam int SW  = $clog2(N_STATES);
  localparam int DSW = (DISPLAY_STABLE > 1) ? $clog2(DISPLAY_STABLE) : 1;

  logic [1:0]       lvl, short_p, long_p;
  logic             chord, chord_any;
  logic [SW-1:0]    sel_q;
  logic [WIDTH-1:0] cand, cur;
  logic [DSW-1:0]   st_cnt;

  // Include the combinational both-high term so the very first overlapping
  // cycle is already suppressed.
  assign chord_any = chord | (&lvl);
  assign o_buttons = lvl;
  assign cur       = i_x[o_sel];

  // Index 0 = PREV, index 1 = NEXT.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    debug_btn #(
      .DEADZONE_WIDTH   (DEADZONE_WIDTH),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_btn (
      .clk      (clk),
      .i_reset  (i_reset),
      .raw      (i_buttons[b]),
      .chord_any(chord_any),
      .level    (lvl[b]),
      .short_p  (short_p[b]),
      .long_p   (long_p[b])
    );
  end

  // Chord latch holds until both buttons are up; o_reset follows the overlap.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      chord   <= 1'b0;
      o_reset <= 1'b0;
    end else begin
      o_reset <= &lvl;
      if (&lvl)            chord <= 1'b1;
      else if (lvl == 2'b00) chord <= 1'b0;
    end
  end

  // Press actions, NEXT taking priority over PREV.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_sel    <= '0;
      o_frozen <= 1'b0;
    end else if (short_p[1]) begin
      o_sel <= (o_sel == SW'(N_STATES - 1)) ? '0 : o_sel + 1'b1;
    end else if (long_p[1]) begin
      o_frozen <= ~o_frozen;
    end else if (short_p[0]) begin
      o_sel <= (o_sel == '0) ? SW'(N_STATES - 1) : o_sel - 1'b1;
    end else if (long_p[0]) begin
      o_sel <= '0;
    end
  end

  // Display filter: bypass on selection change, otherwise a value must hold
  // DISPLAY_STABLE cycles. While frozen the count saturates so an already
  // stable candidate lands right after unfreeze.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      sel_q     <= '0;
      cand      <= '0;
      st_cnt    <= '0;
      o_display <= '0;
    end else begin
      sel_q <= o_sel;
      if (o_sel != sel_q && !o_frozen) begin
        o_display <= cur;
        cand      <= cur;
        st_cnt    <= '0;
      end else if (cur != cand) begin
        cand   <= cur;
        st_cnt <= '0;
      end else if (cand != o_display) begin
        if (st_cnt == DSW'(DISPLAY_STABLE - 1)) begin
          if (!o_frozen) begin
            o_display <= cand;
            st_cnt    <= '0;
          end
        end else begin
          st_cnt <= st_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_debug_panel.sv
// Directed bench for debug_panel with short debounce/long/stable constants.
module tb_debug_panel;
  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      btn;
  logic [3:0][7:0] x;
  logic [1:0]      o_buttons;
  logic [1:0]      o_sel;
  logic            o_frozen;
  logic [7:0]      o_display;
  logic            o_reset;

  int npass = 0, ntot = 0;
  int cyc = 0, rises_next = 0, rise_cyc = 0, frz_toggles = 0, rst_hi = 0;
  bit pb1 = 1'b0, pfz = 1'b0;
  int t0, base, fb, rb;

  debug_panel #(
    .WIDTH(8), .N_STATES(4), .DEADZONE_WIDTH(4),
    .LONG_PRESS_CYCLES(20), .DISPLAY_STABLE(8)
  ) dut (
    .clk(clk), .i_reset(rst), .i_buttons(btn), .i_x(x),
    .o_buttons(o_buttons), .o_sel(o_sel), .o_frozen(o_frozen),
    .o_display(o_display), .o_reset(o_reset)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event counters sampled on the falling edge.
  always @(negedge clk) begin
    if (o_buttons[1] && !pb1) begin
      rises_next <= rises_next + 1;
      rise_cyc   <= cyc;
    end
    if (o_frozen != pfz) frz_toggles <= frz_toggles + 1;
    if (o_reset) rst_hi <= rst_hi + 1;
    pb1 <= o_buttons[1];
    pfz <= o_frozen;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic short_press(input int b);
    btn[b] = 1'b1; tick(8); btn[b] = 1'b0; tick(12);
  endtask

  task automatic long_press(input int b);
    btn[b] = 1'b1; tick(30); btn[b] = 1'b0; tick(12);
  endtask

  task automatic chord(input bit next_first);
    rb = rst_hi;
    btn[1] = 1'b1; tick(3);
    btn[0] = 1'b1; tick(20);
    chk("chord_mid_reset", o_reset, 1);
    tick(20);
    if (next_first) btn[1] = 1'b0; else btn[0] = 1'b0;
    tick(3);
    btn = 2'b00;
    tick(15);
    chk("chord_reset_len", rst_hi - rb, 40);
    chk("chord_reset_low", o_reset, 0);
    chk("chord_sel", o_sel, 0);
    chk("chord_frozen", o_frozen, 1);
  endtask

  initial begin
    rst = 1'b1; btn = 2'b00;
    x[0] = 8'h11; x[1] = 8'h22; x[2] = 8'h33; x[3] = 8'h44;
    tick(3);
    rst = 1'b0;
    chk("rst_buttons", o_buttons, 0);
    chk("rst_sel", o_sel, 0);
    chk("rst_frozen", o_frozen, 0);
    chk("rst_display", o_display, 0);
    chk("rst_reset", o_reset, 0);

    // Bounce then a clean press.
    base = rises_next;
    for (int i = 0; i < 5; i++) begin
      btn[1] = 1'b1; tick(2); btn[1] = 1'b0; tick(2);
    end
    btn[1] = 1'b1; t0 = cyc; tick(10); btn[1] = 1'b0; tick(15);
    chk("bounce_rises", rises_next - base, 1);
    chk("bounce_latency", rise_cyc - t0, 6);
    chk("bounce_sel", o_sel, 1);
    chk("bounce_display", o_display, 8'h22);

    // Wrap both ways.
    short_press(0);
    chk("prev_sel", o_sel, 0);
    chk("prev_display", o_display, 8'h11);
    short_press(0);
    chk("wrap_sel", o_sel, 3);
    chk("wrap_display", o_display, 8'h44);
    short_press(1); short_press(1);
    chk("next_wrap_sel", o_sel, 1);
    chk("next_wrap_display", o_display, 8'h22);

    // Long presses.
    fb = frz_toggles;
    long_press(1);
    chk("long_toggles", frz_toggles - fb, 1);
    chk("long_frozen", o_frozen, 1);
    chk("long_no_step", o_sel, 1);
    short_press(1);
    chk("frozen_step_sel", o_sel, 2);
    chk("frozen_display", o_display, 8'h22);
    long_press(0);
    chk("prev_long_sel", o_sel, 0);
    chk("prev_long_display", o_display, 8'h22);

    // Chords in both release orders.
    chord(1'b0);
    chord(1'b1);

    // Unfreeze: stable candidate for sel 0 lands.
    long_press(1);
    chk("unfreeze", o_frozen, 0);
    chk("unfreeze_display", o_display, 8'h11);

    // Filter: short glitch rejected, held change lands after 9 cycles.
    x[0] = 8'h55; tick(5);
    x[0] = 8'h11; tick(12);
    chk("glitch_display", o_display, 8'h11);
    x[0] = 8'h66; tick(8);
    chk("filt_early", o_display, 8'h11);
    tick(1);
    chk("filt_land", o_display, 8'h66);

    // Reset mid long-press with sel=2 and frozen.
    short_press(1); short_press(1);
    chk("pre_rst_sel", o_sel, 2);
    chk("pre_rst_display", o_display, 8'h33);
    long_press(1);
    chk("pre_rst_frozen", o_frozen, 1);
    btn[1] = 1'b1; tick(15);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("mid_rst_buttons", o_buttons, 0);
    chk("mid_rst_sel", o_sel, 0);
    chk("mid_rst_frozen", o_frozen, 0);
    chk("mid_rst_display", o_display, 0);
    chk("mid_rst_reset", o_reset, 0);
    tick(20);
    chk("requal_level", o_buttons, 2'b10);
    tick(20);
    chk("held_no_freeze", o_frozen, 0);
    chk("held_no_step", o_sel, 0);
    btn[1] = 1'b0; tick(15);
    chk("release_no_step", o_sel, 0);
    chk("release_no_freeze", o_frozen, 0);
    short_press(1);
    chk("repress_sel", o_sel, 1);
    chk("repress_display", o_display, 8'h22);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
